// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and the cycle latencies seen by the pipeline control.
`timescale 1ns/1ps
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Edges from the start edge to the edge that exposes done.
    localparam int MD_LATENCY      = 33;
    localparam int MD_FAST_LATENCY = 1;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*XLEN accumulator: shift-add for multiply,
// restore-subtract for divide. Purely combinational.
`timescale 1ns/1ps
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    always_comb begin
        // Multiply: {product_hi, multiplier} shifts right, adding at bit 0.
        add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);

        // Divide: {remainder, dividend} shifts left; partial needs one extra
        // bit because the shifted remainder can reach 2*divisor-1.
        partial = acc_in[2*XLEN-1:XLEN-1];
        diff    = partial[XLEN-1:0] - operand;

        if (is_div) begin
            if (partial >= {1'b0, operand})
                acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            else
                acc_out = {acc_in[2*XLEN-2:XLEN-1], acc_in[XLEN-2:0], 1'b0};
        end else begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are latched at start,
// 32 radix-2 steps run in CALC, and signs are fixed up in DONE.
`timescale 1ns/1ps
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CALC_STEPS = MD_LATENCY - MD_FAST_LATENCY;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CALC_STEPS - 1);
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               a_neg, b_neg, fast_q;
    logic [XLEN-1:0]    divisor_q;
    logic [2*XLEN-1:0]  acc_q, acc_step;
    logic [XLEN-1:0]    result_q, final_res;

    logic               div_op, a_sgn, b_sgn, a_neg_in, b_neg_in, fast_in;
    logic [XLEN-1:0]    a_mag_in, b_mag_in, fast_res;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot, rem;

    // Launch decode: which operands are signed, their magnitudes, and
    // whether the answer is known without iterating.
    always_comb begin
        div_op   = funct3[2];
        a_sgn    = div_op ? ~funct3[0] : (funct3 != MD_MULHU);
        b_sgn    = div_op ? ~funct3[0] : ~funct3[1];
        a_neg_in = a_sgn & op_a[XLEN-1];
        b_neg_in = b_sgn & op_b[XLEN-1];
        a_mag_in = a_neg_in ? -op_a : op_a;
        b_mag_in = b_neg_in ? -op_b : op_b;

        fast_in  = 1'b0;
        fast_res = '0;
        if (div_op) begin
            if (op_b == '0) begin
                fast_in  = 1'b1;
                fast_res = funct3[1] ? op_a : '1;
            end else if (~funct3[0] && op_a == INT_MIN && op_b == '1) begin
                fast_in  = 1'b1;
                fast_res = funct3[1] ? '0 : op_a;
            end
        end
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .acc_in  (acc_q),
        .operand (divisor_q),
        .acc_out (acc_step)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = fast_in ? DONE : CALC;
            CALC:    if (kill) state_nxt = IDLE;
                     else if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod = (a_neg ^ b_neg) ? -acc_q : acc_q;
        quot = (a_neg ^ b_neg) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = a_neg ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        if (fast_q)
            final_res = acc_q[XLEN-1:0];
        else if (op_q[2])
            final_res = op_q[1] ? rem : quot;
        else
            final_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) && !kill;
    // NOTE: the fresh answer is muxed out during the done cycle itself; the
    // register only captures it on the way out, so a kill in DONE leaves it alone.
    assign result = done ? final_res : result_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= MD_MUL;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            fast_q    <= 1'b0;
            divisor_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (start) begin
                    op_q      <= funct3;
                    a_neg     <= a_neg_in;
                    b_neg     <= b_neg_in;
                    fast_q    <= fast_in;
                    divisor_q <= b_mag_in;
                    cnt       <= '0;
                    acc_q     <= {{XLEN{1'b0}}, (fast_in ? fast_res : a_mag_in)};
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt   <= cnt + CNT_W'(1);
                end
                DONE: if (!kill) result_q <= final_res;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit for the processor's execute stage, next to the ALU.
- Operands come from the register-file read ports (rs1 data, rs2 data). It returns a 32-bit result to the writeback mux with a start/done handshake.
- The control path holds the pipeline/PC while busy, so multiply and divide run in hardware instead of the current software loops.

Parameters:
- XLEN, 32: operand and result width. Only 32 is supported.
- CNT_W, 5: iteration counter width, equal to clog2(XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request. Sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value. Sampled with start.
- op_b  input  XLEN  rs2 value. Sampled with start.
- kill  input  1  abort the operation in flight (flush).
- busy  output  1  high from the edge after an accepted start until the edge that leaves DONE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  final result. Holds its value until the next done.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0, counter=0, internal accumulators=0.
  - Reset has priority over kill and start.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 latches funct3, the operand magnitudes and the sign flags.
  - Normal path goes to CALC with counter=0.
  - Fast path (see special cases) goes directly to DONE.
- CALC:
  - One radix-2 step per cycle, for exactly XLEN (32) cycles.
  - Leaves for DONE on the edge where counter==XLEN-1.
- DONE:
  - done=1, busy=1.
  - Always returns to IDLE on the next edge.
- Latency:
  - start sampled at edge E0: done is visible after E33 (normal) or after E1 (fast path).
  - Back-to-back: a new start is accepted in the cycle after done.
- start while busy: ignored, with no effect on the operation in flight.
- kill while in CALC or DONE: IDLE on the next edge, done not asserted, result keeps its previous value. kill in IDLE has no effect; start in the same cycle is still accepted.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*XLEN product.
  - Sign handling: MUL and MULH treat both operands as signed; MULHSU treats op_a as signed, op_b unsigned; MULHU is fully unsigned.
  - If the operand signs differ, the 64-bit product is two's-complement negated in DONE.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Signed ops: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - DIVU/REMU operate on raw unsigned values.
- Special cases (fast path, no CALC):
  - op_b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow, DIV with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
  - Multiply has no fast path; MUL by 0 still takes 33 cycles.
- All arithmetic is modulo 2^XLEN (or 2^2XLEN for the product). No exceptions or flags are raised.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 encoding constants (MD_MUL ... MD_REMU).
  - FSM state typedef {IDLE, CALC, DONE}.
  - MD_LATENCY=33 and MD_FAST_LATENCY=1.
- The top-level decoder uses the package to drive start and to stall the PC.
- No sub-module is required. The single-step datapath may optionally be split out as muldiv_step (one combinational iteration: shift-add or restore-subtract).

Test Plan:
- DIVU: op_a=500, op_b=25, start at E0 → done only after E33, result=20; REMU → 0; busy high E1..E33.
- MUL 500*25 → 12500. MULH 0xFFFFFFFF*0xFFFFFFFF → 0, MUL → 1. MULHU same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 → 0xFFFFFFFF.
- Signed divide: DIV -7/2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); DIV 7/-2 → -3, REM → 1.
- Divide by zero: DIV 123/0 → 0xFFFFFFFF with done after E1; REMU 123/0 → 123. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, done after E1.
- Abort: kill at E10 of a DIV → IDLE at E11, no done pulse, result unchanged. Start at E12 with MUL 3*4 → done after E45, result 12.
- Start while busy: a second start at E5 with different operands is ignored, first result returned. rst=1 at E20 → busy=0, done=0, result=0 after E20.
